// File: rtl/demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// demux_1x2_stream
//
// Registered 1-to-2 stream demultiplexer. Each accepted input word goes to
// output A (in_sel=0) or output B (in_sel=1). It then waits in that branch's
// 2-entry buffer until downstream takes it. The two branches are independent.
// A stalled branch only blocks input words addressed to it. Each branch sustains
// one word per cycle while its downstream stays ready.
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   in_data   in   DATAWIDTH  input word
//   in_sel    in   1          destination: 0 -> A, 1 -> B
//   in_valid  in   1          in_data/in_sel valid
//   in_ready  out  1          destination buffer has room (low during reset)
//   a_data    out  DATAWIDTH  head word of buffer A
//   a_valid   out  1          buffer A non-empty
//   a_ready   in   1          downstream A accepts
//   b_data    out  DATAWIDTH  head word of buffer B
//   b_valid   out  1          buffer B non-empty
//   b_ready   in   1          downstream B accepts
//   a_xfers   out  CNTWIDTH   completed A output handshakes (wrapping)
//   b_xfers   out  CNTWIDTH   completed B output handshakes (wrapping)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// demux_stream_buf
//
// One output branch. It holds a 2-entry FIFO with 1-bit pointers, a registered
// valid flag and a wrapping handshake counter.
//
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   push         write push_data this cycle (never asserted while full)
//   push_data    word to enqueue
//   full         two entries held; upstream must not push
//   data         head word (mem[rd_ptr])
//   valid        buffer non-empty, registered
//   ready        downstream accepts the head word
//   xfers        count of valid & ready handshakes, wraps mod 2^CNTWIDTH
// -----------------------------------------------------------------------------
module demux_stream_buf #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATAWIDTH-1:0] push_data,
    output logic                 full,
    output logic [DATAWIDTH-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic [CNTWIDTH-1:0]  xfers
);

    logic [DATAWIDTH-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [1:0]           count_next;
    logic                 pop;

    // A pop needs a registered valid word, so it can never occur while empty.
    assign pop  = valid & ready;
    assign full = (count == 2'd2);
    assign data = mem[rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;   // idle, or push+pop (count unchanged)
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage entries are reset too, because the head word must
            // read as zero after reset, not only be hidden behind valid=0.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            valid  <= 1'b0;
            xfers  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                xfers  <= xfers + 1'b1;
            end
            count <= count_next;
            valid <= (count_next != 2'd0);
        end
    end

endmodule

module demux_1x2_stream #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [DATAWIDTH-1:0] b_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [CNTWIDTH-1:0]  a_xfers,
    output logic [CNTWIDTH-1:0]  b_xfers
);

    logic a_full;
    logic b_full;
    logic accept;
    logic a_push;
    logic b_push;

    // Readiness looks only at the addressed buffer's registered fill level. A
    // full buffer refuses input even if it drains this same cycle. This keeps
    // in_ready free of any path from a_ready/b_ready. rst_n gates it so nothing
    // is offered as accepted while the block is held in reset.
    assign in_ready = rst_n & (in_sel ? ~b_full : ~a_full);
    assign accept   = in_valid & in_ready;
    assign a_push   = accept & ~in_sel;
    assign b_push   = accept &  in_sel;

    demux_stream_buf #(
        .DATAWIDTH (DATAWIDTH),
        .CNTWIDTH  (CNTWIDTH)
    ) u_buf_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (in_data),
        .full      (a_full),
        .data      (a_data),
        .valid     (a_valid),
        .ready     (a_ready),
        .xfers     (a_xfers)
    );

    demux_stream_buf #(
        .DATAWIDTH (DATAWIDTH),
        .CNTWIDTH  (CNTWIDTH)
    ) u_buf_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (in_data),
        .full      (b_full),
        .data      (b_data),
        .valid     (b_valid),
        .ready     (b_ready),
        .xfers     (b_xfers)
    );

endmodule

// File: tb/tb_demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1x2_stream
//
// Directed bench for demux_1x2_stream. Inputs change on the falling edge.
// in_ready is sampled just before the rising edge. Registered outputs are
// sampled 1 time unit after the rising edge. A second instance with a 4-bit
// counter shares the same stimulus so counter wrap can be observed.
// -----------------------------------------------------------------------------
module tb_demux_1x2_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_ready;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] a_xfers;
    logic [15:0] b_xfers;

    // Narrow-counter instance.
    logic        n_in_ready;
    logic [7:0]  n_a_data;
    logic        n_a_valid;
    logic [7:0]  n_b_data;
    logic        n_b_valid;
    logic [3:0]  n_a_xfers;
    logic [3:0]  n_b_xfers;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1x2_stream #(.DATAWIDTH(8), .CNTWIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_xfers  (a_xfers),
        .b_xfers  (b_xfers)
    );

    demux_1x2_stream #(.DATAWIDTH(8), .CNTWIDTH(4)) dut_narrow (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (n_in_ready),
        .a_data   (n_a_data),
        .a_valid  (n_a_valid),
        .a_ready  (a_ready),
        .b_data   (n_b_data),
        .b_valid  (n_b_valid),
        .b_ready  (b_ready),
        .a_xfers  (n_a_xfers),
        .b_xfers  (n_b_xfers)
    );

    typedef struct {
        logic [7:0] data;
        logic       sel;
        logic       valid;
        logic       a_rdy;
        logic       b_rdy;
        logic       exp_in_ready;   // before the edge
        logic       exp_a_valid;    // after the edge
        logic [7:0] exp_a_data;
        logic       exp_b_valid;
        logic [7:0] exp_b_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [7:0] d, input logic s, input logic v,
                                 input logic ar, input logic br, input logic eir,
                                 input logic eav, input logic [7:0] ead,
                                 input logic ebv, input logic [7:0] ebd);
        vec_t r;
        r.data = d; r.sel = s; r.valid = v; r.a_rdy = ar; r.b_rdy = br;
        r.exp_in_ready = eir; r.exp_a_valid = eav; r.exp_a_data = ead;
        r.exp_b_valid = ebv; r.exp_b_data = ebd;
        return r;
    endfunction

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_data  = vecs[i].data;
            in_sel   = vecs[i].sel;
            in_valid = vecs[i].valid;
            a_ready  = vecs[i].a_rdy;
            b_ready  = vecs[i].b_rdy;
            #1;
            check($sformatf("%s[%0d] in_ready", tag, i), in_ready, vecs[i].exp_in_ready);
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] a_valid", tag, i), a_valid, vecs[i].exp_a_valid);
            if (vecs[i].exp_a_valid)
                check($sformatf("%s[%0d] a_data", tag, i), a_data, vecs[i].exp_a_data);
            check($sformatf("%s[%0d] b_valid", tag, i), b_valid, vecs[i].exp_b_valid);
            if (vecs[i].exp_b_valid)
                check($sformatf("%s[%0d] b_data", tag, i), b_data, vecs[i].exp_b_data);
        end
        vecs.delete();
    endtask

    task automatic idle_inputs();
        in_data  = 8'h00;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- T1: reset with in_valid asserted ----------------
        rst_n    = 1'b0;
        idle_inputs();
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        check("t1 in_ready in reset", in_ready, 1'b0);
        check("t1 a_valid", a_valid, 1'b0);
        check("t1 b_valid", b_valid, 1'b0);
        check("t1 a_data", a_data, 8'h00);
        check("t1 b_data", b_data, 8'h00);
        check("t1 a_xfers", a_xfers, 16'd0);
        check("t1 b_xfers", b_xfers, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("t1 in_ready after release", in_ready, 1'b1);

        // ---------------- T2: routing, both downstreams ready ----------------
        //             data   sel   v     ar    br    ir    av    ad     bv    bd
        vecs.push_back(mkv(8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00));
        vecs.push_back(mkv(8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22));
        vecs.push_back(mkv(8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00));
        vecs.push_back(mkv(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
        run_vectors("t2");
        check("t2 a_xfers", a_xfers, 16'd2);
        check("t2 b_xfers", b_xfers, 16'd1);

        // ---------------- T3: backpressure on B only ----------------
        vecs.push_back(mkv(8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA1));
        vecs.push_back(mkv(8'hA2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA1));
        vecs.push_back(mkv(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA1));
        vecs.push_back(mkv(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'hA1));
        // B full but popping this cycle: input for B still refused.
        vecs.push_back(mkv(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA2));
        // count 1, push+pop: head advances to the new word.
        vecs.push_back(mkv(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA3));
        vecs.push_back(mkv(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
        run_vectors("t3");
        check("t3 a_xfers", a_xfers, 16'd3);
        check("t3 b_xfers", b_xfers, 16'd4);

        // ---------------- T4: 100-word stream on A ----------------
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_data  = 8'(i);
            in_sel   = 1'b0;
            in_valid = 1'b1;
            #1;
            check($sformatf("t4[%0d] in_ready", i), in_ready, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("t4[%0d] a_valid", i), a_valid, 1'b1);
            check($sformatf("t4[%0d] a_data", i), a_data, 32'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t4 a_valid drained", a_valid, 1'b0);
        check("t4 a_xfers", a_xfers, 16'd100);
        check("t4 narrow a_xfers", n_a_xfers, 4'd4);

        // ---------------- T5: counter wrap with CNTWIDTH=4 ----------------
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_data  = 8'(8'hC0 + i);
            in_sel   = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5 wide a_xfers", a_xfers, 16'd17);
        check("t5 narrow a_xfers wrapped", n_a_xfers, 4'd1);

        // ---------------- T6: reset while B holds two words ----------------
        do_reset();
        @(negedge clk);
        b_ready  = 1'b0;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB1;
        @(negedge clk);
        in_data  = 8'hB2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t6 b_valid before reset", b_valid, 1'b1);
        check("t6 b_data before reset", b_data, 8'hB1);
        check("t6 in_ready B full", in_ready, 1'b0);
        rst_n   = 1'b0;
        b_ready = 1'b1;
        #1;
        check("t6 b_valid in reset", b_valid, 1'b0);
        check("t6 b_data in reset", b_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6[%0d] b_valid after release", i), b_valid, 1'b0);
            check($sformatf("t6[%0d] b_xfers after release", i), b_xfers, 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
